rfile_wbq: RTL and testbench
============================

RFILE_WBQ -- requirements
Module: rfile_wbq

Interface
REQ-001 Parameter DEPTH, default 4, queue entries, power of two, 2..16, SHALL be supported.
REQ-002 Parameter ADR_W, default 4, register address width, SHALL match register-file address width.
REQ-003 Parameter DAT_W, default 16, register data width, SHALL match register-file data width.
REQ-004 Ports SHALL be as follows, all widths in bits:
 clk  in  1  sole clock, all state updates on rising edge
 rst  in  1  synchronous, active-high reset
 in_valid  in  1  execute unit presents a write request
 in_ready  out  1  queue can accept a request this cycle
 in_adr  in  ADR_W  destination register of the request
 in_dat  in  DAT_W  result data of the request
 wb_hold  in  1  register-file write port unavailable; no drain this cycle
 rfile_we  out  1  register-file write enable, registered
 cadr  out  ADR_W  register-file write address, registered
 c  out  DAT_W  register-file write data, registered
 aadr, badr  in  ADR_W each  operand addresses being read from the register file
 a_hit, b_hit  out  1 each  a pending, uncommitted write targets aadr / badr
 a_fwd, b_fwd  out  DAT_W each  newest pending data for aadr / badr
 pending  out  log2(DEPTH)+1  number of entries in the queue, excluding the output stage

Function
REQ-005 Push SHALL occur at a rising edge where in_valid=1 and in_ready=1; the entry {in_adr,in_dat} is written at the tail.
REQ-006 in_ready SHALL equal (pending<DEPTH) and not rst; a pop in the same cycle SHALL NOT grant an extra slot.
REQ-007 Pop SHALL occur at a rising edge where pending>0 (value before the edge) and wb_hold=0; the head is loaded into {cadr,c} and rfile_we is set to 1.
REQ-008 At every edge without a pop, rfile_we SHALL be set to 0; cadr and c SHALL keep their previous values.
REQ-009 An entry pushed into an empty queue at edge E SHALL be popped no earlier than edge E+1, so rfile_we is high in cycle E+1..E+2 at minimum; there SHALL be no same-edge push-to-output bypass.
REQ-010 Simultaneous push and pop SHALL leave pending unchanged; push only +1; pop only -1.
REQ-011 Drain order SHALL be strict FIFO; repeated writes to one address SHALL all be issued, in arrival order.
REQ-012 Head and tail pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from pending, not from pointer equality.
REQ-013 a_hit SHALL be 1 when aadr matches any valid queue entry or the output stage while rfile_we=1; b_hit is likewise defined for badr.
REQ-014 a_fwd/b_fwd SHALL return the data of the youngest match: queue entries newest to oldest, then the output stage; SHALL be 0 when the corresponding hit is 0.
REQ-015 Lookups SHALL be combinational from current state only; a request being pushed in the same cycle SHALL NOT be matched.
REQ-016 in_valid with in_ready=0 SHALL be ignored with no state change; the requester holds it.
REQ-017 wb_hold=1 with pending=0 SHALL have no effect other than rfile_we=0 at the next edge.

Reset
REQ-018 At an edge with rst=1: pending=0, pointers=0, rfile_we=0, cadr=0, c=0; all queue entries become invalid.
REQ-019 While rst=1, in_ready SHALL be 0, no push or pop SHALL occur, and a_hit=b_hit=0 after the reset edge.
REQ-020 A reset asserted mid-drain SHALL discard all queued and output-stage writes; rfile_we SHALL be 0 from the cycle after the reset edge.

Verification
REQ-021 Single write: push {5,16'h1234} into an empty queue -> next cycle pending=1, a_hit=1 for aadr=5 with a_fwd=16'h1234; after one more edge rfile_we=1, cadr=5, c=16'h1234; after one further edge rfile_we=0 and a_hit=0.
REQ-022 Fill: wb_hold=1, push 4 requests -> in_ready=0, pending=4; a fifth in_valid is ignored; release wb_hold -> writes issued on 4 consecutive cycles in push order.
REQ-023 Youngest-wins: push {3,16'h00AA} then {3,16'h00BB} with wb_hold=1 -> aadr=3 gives a_fwd=16'h00BB; drain -> cadr=3 with c=16'h00AA, then c=16'h00BB.
REQ-024 Full with push and pop: pending=4, wb_hold=0, in_valid=1 -> no push that cycle (in_ready=0), pop occurs, pending=3; push accepted the following cycle.
REQ-025 Wrap: 10 push/pop cycles with DEPTH=4 and random addresses -> issued sequence equals pushed sequence exactly.
REQ-026 Reset mid-drain: pending=3, rfile_we=1, assert rst for one edge -> rfile_we=0, pending=0, a_hit=b_hit=0, in_ready=1 once rst=0.

Source files
------------

// File: rtl/rfile_wbq.sv
// Register-file write-back queue: buffers execute-unit results, drains them in FIFO order
// through a registered write port, and forwards the youngest pending data to operand reads.
module rfile_wbq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ADR_W = 4,
    parameter int unsigned DAT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADR_W-1:0]           in_adr,
    input  logic [DAT_W-1:0]           in_dat,
    input  logic                       wb_hold,
    output logic                       rfile_we,
    output logic [ADR_W-1:0]           cadr,
    output logic [DAT_W-1:0]           c,
    input  logic [ADR_W-1:0]           aadr,
    input  logic [ADR_W-1:0]           badr,
    output logic                       a_hit,
    output logic                       b_hit,
    output logic [DAT_W-1:0]           a_fwd,
    output logic [DAT_W-1:0]           b_fwd,
    output logic [$clog2(DEPTH):0]     pending
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADR_W-1:0] adr_q [DEPTH];
    logic [ADR_W-1:0] adr_d [DEPTH];
    logic [DAT_W-1:0] dat_q [DEPTH];
    logic [DAT_W-1:0] dat_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] cadr_q, cadr_d;
    logic [DAT_W-1:0] c_q, c_d;

    logic push, pop;

    // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot.
    assign in_ready = (cnt_q < FULL_CNT) && !rst;
    assign push     = in_valid && in_ready;
    assign pop      = (cnt_q != '0) && !wb_hold;

    assign rfile_we = we_q;
    assign cadr     = cadr_q;
    assign c        = c_q;
    assign pending  = cnt_q;

    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        we_d   = 1'b0;
        cadr_d = cadr_q;
        c_d    = c_q;

        if (push) begin
            adr_d[tail_q] = in_adr;
            dat_d[tail_q] = in_dat;
            tail_d        = tail_q + 1'b1;
        end
        if (pop) begin
            we_d   = 1'b1;
            cadr_d = adr_q[head_q];
            c_d    = dat_q[head_q];
            head_d = head_q + 1'b1;
        end

        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Entry storage needs no reset: validity comes from the count.
    always_ff @(posedge clk) begin
        adr_q <= adr_d;
        dat_q <= dat_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            we_q   <= 1'b0;
            cadr_q <= '0;
            c_q    <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            we_q   <= we_d;
            cadr_q <= cadr_d;
            c_q    <= c_d;
        end
    end

    // Scan output stage first, then entries oldest to newest, so the last match is the youngest.
    logic [PTR_W-1:0] idx;

    always_comb begin
        a_hit = 1'b0;
        b_hit = 1'b0;
        a_fwd = '0;
        b_fwd = '0;
        idx   = '0;

        if (we_q && (cadr_q == aadr)) begin
            a_hit = 1'b1;
            a_fwd = c_q;
        end
        if (we_q && (cadr_q == badr)) begin
            b_hit = 1'b1;
            b_fwd = c_q;
        end

        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < cnt_q) begin
                if (adr_q[idx] == aadr) begin
                    a_hit = 1'b1;
                    a_fwd = dat_q[idx];
                end
                if (adr_q[idx] == badr) begin
                    b_hit = 1'b1;
                    b_fwd = dat_q[idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_rfile_wbq.sv
// Bench for rfile_wbq: directed scenarios plus random traffic, checked every cycle against a
// queue-based reference model of the write-back behaviour.
module tb_rfile_wbq;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ADR_W = 4;
    localparam int unsigned DAT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [ADR_W-1:0] in_adr;
    logic [DAT_W-1:0] in_dat;
    logic             wb_hold;
    logic             rfile_we;
    logic [ADR_W-1:0] cadr;
    logic [DAT_W-1:0] c;
    logic [ADR_W-1:0] aadr, badr;
    logic             a_hit, b_hit;
    logic [DAT_W-1:0] a_fwd, b_fwd;
    logic [2:0]       pending;

    rfile_wbq #(.DEPTH(DEPTH), .ADR_W(ADR_W), .DAT_W(DAT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_adr(in_adr), .in_dat(in_dat), .wb_hold(wb_hold), .rfile_we(rfile_we),
        .cadr(cadr), .c(c), .aadr(aadr), .badr(badr), .a_hit(a_hit), .b_hit(b_hit),
        .a_fwd(a_fwd), .b_fwd(b_fwd), .pending(pending)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: pending entries as {adr,dat}, front = oldest.
    logic [ADR_W+DAT_W-1:0] mq[$];
    logic             m_we   = 1'b0;
    logic [ADR_W-1:0] m_cadr = '0;
    logic [DAT_W-1:0] m_c    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [ADR_W-1:0] adr, output logic hit,
                                output logic [DAT_W-1:0] dat);
        hit = 1'b0;
        dat = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i][ADR_W+DAT_W-1:DAT_W] == adr) begin
                hit = 1'b1;
                dat = mq[i][DAT_W-1:0];
                return;
            end
        end
        if (m_we && m_cadr == adr) begin
            hit = 1'b1;
            dat = m_c;
        end
    endtask

    // Compare all outputs against the model, then take one clock edge and advance the model.
    task automatic tick();
        logic             ready, push, pop, ha, hb;
        logic [DAT_W-1:0] fa, fb;
        #1;
        ready = (mq.size() < DEPTH) && !rst;
        model_lookup(aadr, ha, fa);
        model_lookup(badr, hb, fb);
        check("in_ready", 32'(in_ready), 32'(ready));
        check("pending",  32'(pending),  32'(mq.size()));
        check("rfile_we", 32'(rfile_we), 32'(m_we));
        check("cadr",     32'(cadr),     32'(m_cadr));
        check("c",        32'(c),        32'(m_c));
        check("a_hit",    32'(a_hit),    32'(ha));
        check("a_fwd",    32'(a_fwd),    32'(fa));
        check("b_hit",    32'(b_hit),    32'(hb));
        check("b_fwd",    32'(b_fwd),    32'(fb));
        push = in_valid && ready;
        pop  = !rst && mq.size() > 0 && !wb_hold;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_we = 1'b0; m_cadr = '0; m_c = '0;
        end else begin
            if (pop) begin
                m_we   = 1'b1;
                m_cadr = mq[0][ADR_W+DAT_W-1:DAT_W];
                m_c    = mq[0][DAT_W-1:0];
                void'(mq.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (push) mq.push_back({in_adr, in_dat});
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; wb_hold = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    logic [DAT_W-1:0] fill_dat [4];
    logic [ADR_W-1:0] fill_adr [4];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_adr = '0; in_dat = '0; wb_hold = 1'b0;
        aadr = '0; badr = '0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_pending", 32'(pending), 32'd0);
        check("reset_we", 32'(rfile_we), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);

        // Single write with forwarding then commit.
        in_valid = 1'b1; in_adr = 4'd5; in_dat = 16'h1234; aadr = 4'd5; badr = 4'd6;
        tick();
        in_valid = 1'b0;
        #1;
        check("single_pending", 32'(pending), 32'd1);
        check("single_ahit", 32'(a_hit), 32'd1);
        check("single_afwd", 32'(a_fwd), 32'h1234);
        check("single_we_lo", 32'(rfile_we), 32'd0);
        tick();
        check("single_we", 32'(rfile_we), 32'd1);
        check("single_cadr", 32'(cadr), 32'd5);
        check("single_c", 32'(c), 32'h1234);
        tick();
        check("single_we_off", 32'(rfile_we), 32'd0);
        check("single_ahit_off", 32'(a_hit), 32'd0);

        // Fill under hold, fifth request ignored, then drain in order.
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fill_adr[i] = ADR_W'(i + 8);
            fill_dat[i] = DAT_W'($urandom);
            in_valid = 1'b1; in_adr = fill_adr[i]; in_dat = fill_dat[i];
            tick();
        end
        in_adr = 4'd1; in_dat = 16'hDEAD;
        #1;
        check("fill_ready", 32'(in_ready), 32'd0);
        check("fill_pending", 32'(pending), 32'd4);
        tick();
        check("fill_ignored", 32'(pending), 32'd4);
        in_valid = 1'b0; wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("drain_we", 32'(rfile_we), 32'd1);
            check("drain_cadr", 32'(cadr), 32'(fill_adr[i]));
            check("drain_c", 32'(c), 32'(fill_dat[i]));
        end
        tick();

        // Youngest-wins forwarding.
        wb_hold = 1'b1; aadr = 4'd3;
        in_valid = 1'b1; in_adr = 4'd3; in_dat = 16'h00AA;
        tick();
        in_dat = 16'h00BB;
        tick();
        in_valid = 1'b0;
        #1;
        check("young_afwd", 32'(a_fwd), 32'h00BB);
        wb_hold = 1'b0;
        tick();
        check("young_c0", 32'(c), 32'h00AA);
        check("young_cadr", 32'(cadr), 32'd3);
        tick();
        check("young_c1", 32'(c), 32'h00BB);
        tick();

        // Full with simultaneous request and pop.
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_adr = ADR_W'($urandom); in_dat = DAT_W'($urandom);
            tick();
        end
        wb_hold = 1'b0; in_adr = 4'd7; in_dat = 16'h7777;
        #1;
        check("full_ready", 32'(in_ready), 32'd0);
        tick();
        check("full_pop_pending", 32'(pending), 32'd3);
        check("full_pop_ready", 32'(in_ready), 32'd1);
        tick();
        check("full_pushpop_pending", 32'(pending), 32'd3);
        in_valid = 1'b0;
        repeat (4) tick();

        // Reset mid-drain.
        wb_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_adr = ADR_W'(i); in_dat = DAT_W'($urandom);
            tick();
        end
        in_valid = 1'b0; wb_hold = 1'b0;
        tick();
        check("mid_pending", 32'(pending), 32'd3);
        check("mid_we", 32'(rfile_we), 32'd1);
        rst = 1'b1; aadr = 4'd1; badr = 4'd2;
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_we", 32'(rfile_we), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ahit", 32'(a_hit), 32'd0);
        check("rst_bhit", 32'(b_hit), 32'd0);
        check("rst_ready_after", 32'(in_ready), 32'd1);

        // Random traffic, including wrap-around and occasional reset.
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = $urandom_range(0, 3) != 0;
            wb_hold  = $urandom_range(0, 2) == 0;
            in_adr   = ADR_W'($urandom_range(0, 5));
            in_dat   = DAT_W'($urandom);
            aadr     = ADR_W'($urandom_range(0, 5));
            badr     = ADR_W'($urandom_range(0, 5));
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; wb_hold = 1'b0;
        repeat (6) tick();
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
